powlib_graycntr: RTL and testbench
==================================

# powlib_graycntr

Parametrised up/down counter that keeps a binary count and its Gray-coded image in lock-step registers, with clear, load and wrap-or-saturate mode. It is the successor to the separate counter → Gray-encode-FF → Gray-decode-FF chain. Both encodings are valid in the same cycle, with no extra pipeline stage. It is intended as the pointer source for clock-crossing FIFOs and for position counters whose Gray value is sampled by another domain.

## Interface
Parameters:
- W, 4, counter width in bits (W ≥ 2)
- INIT, 0, binary reset/clear value (0 ≤ INIT ≤ 2^W−1)
- MODE, 0, 0 = wrap modulo 2^W, 1 = saturate at 0 and 2^W−1

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising clk edge resets)
- adv  in  1  advance one step in the direction given by dir
- dir  in  1  1 = count up, 0 = count down
- clr  in  1  synchronous clear to INIT
- ld   in  1  synchronous load of ldval
- ldval  in  W  binary load value
- cntr  out  W  registered binary count
- gray  out  W  registered Gray code of cntr, equal to cntr ^ (cntr >> 1)
- wrap  out  1  registered one-cycle pulse, set when a step wraps the count
- sat  out  1  registered; high while a saturating step is blocked
- err  out  1  sticky consistency-error flag (see Configuration)

## Operation
- Next binary value nxt, by priority:
  - rst==0 → INIT
  - else clr → INIT
  - else ld → ldval
  - else adv → step
  - else hold
- Step, MODE 0:
  - nxt = cntr ± 1 mod 2^W
  - wrap = 1 for that cycle when up from 2^W−1 to 0, or down from 0 to 2^W−1
- Step, MODE 1:
  - Up at 2^W−1 holds and sets sat=1; down at 0 holds and sets sat=1.
  - wrap is never set in MODE 1.
- sat is 0 whenever adv=0, or on any cycle where clr or ld is taken.
- gray is registered from bin2gray(nxt), never from cntr, so gray and cntr always describe the same value.
- Any single adv step changes exactly one bit of gray, including across wrap. A hold or a saturate step changes no bits.
- clr and ld may change multiple gray bits. Consumers in another domain must only sample across clr/ld while quiesced.
- Reset values of outputs:
  - cntr = INIT
  - gray = INIT ^ (INIT >> 1)
  - wrap = 0, sat = 0, err = 0
- Reset mid-count wins over all other inputs in the same cycle, and the next cycle starts from INIT.
- Simultaneous clr and ld: clr wins and ldval is ignored.
- Simultaneous ld and adv: the load wins, with no step applied to ldval.

## Timing
- Latency 1 clk: inputs sampled at edge n are visible on cntr, gray, wrap and sat after edge n.
- There is no combinational path from any input to any output.
- One step per cycle maximum. adv held high counts every cycle.
- wrap and sat are valid in the same cycle as the cntr value they describe.

## Configuration
- POWLIB_GRAYCNTR_CHECK_EN defined:
  - Compiles in an internal Gray-decode register and a checker. The checker runs on every cycle with rst==1 that follows another such cycle, where the previous cycle had neither clr nor ld.
  - It verifies that gray differs from its previous value in ≤ 1 bit.
  - It verifies that gray2bin(gray) == cntr.
  - On a violation it sets err and keeps it set until reset, and issues a $display with the simulation time and both values.
- POWLIB_GRAYCNTR_CHECK_EN not defined: checker logic is absent and err is tied to 0. The port list is identical in both builds.

## Test plan
All scenarios use W=4, INIT=0 unless stated.
- Reset and run up: rst=0 for 2 clk, then adv=1, dir=1 for 20 clk.
  - cntr runs 0,1,…,15,0,1,2,3; gray runs 0,1,3,2,6,…,8 (at 15),0.
  - wrap pulses exactly once, in the cycle cntr becomes 0.
  - err stays 0.
- Count down with wrap, MODE 0, INIT=2: adv=1, dir=0 for 4 clk.
  - cntr 2 → 1 → 0 → 15 → 14; wrap=1 only with cntr=15; gray at 15 = 8.
- Saturate, MODE 1: start from ld with ldval=14, then adv=1, dir=1 for 4 clk.
  - cntr 14, 15, 15, 15; sat=1 for the two blocked cycles; wrap stays 0.
  - Then dir=0: cntr 14 and sat=0.
- Priority: in one cycle assert clr=1, ld=1 (ldval=9), adv=1.
  - cntr=0, gray=0.
  - Next cycle ld=1 with ldval=9 and adv=1: cntr=9, gray=13.
- Reset mid-operation: count to 7, then rst=0 for one cycle with adv=1.
  - Next cycle cntr=0, gray=0, wrap=0, sat=0, err=0; counting resumes from 0 after rst=1.
- Checker, with the macro defined: random adv, dir, clr and ld for 10,000 cycles with both MODE values.
  - err stays 0, and every cycle satisfies gray == cntr ^ (cntr >> 1).
  - Then force a two-bit flip on gray: err rises 1 clk later and stays high until rst=0.

Source files
------------

// File: rtl/powlib_graycntr.sv
// Up/down counter keeping binary and Gray images in lock-step registers, with clear, load and wrap/saturate modes.
// Optional consistency checker compiled in with POWLIB_GRAYCNTR_CHECK_EN; err is tied low otherwise.
module powlib_graycntr #(
    parameter int          W    = 4,
    parameter int unsigned INIT = 0,
    parameter int          MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         dir,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ldval,
    output logic [W-1:0] cntr,
    output logic [W-1:0] gray,
    output logic         wrap,
    output logic         sat,
    output logic         err
);

    localparam logic [W-1:0] INIT_V = W'(INIT);
    localparam logic [W-1:0] MAX_V  = {W{1'b1}};

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [W-1:0] nxt;
    logic         wrap_nxt;
    logic         sat_nxt;

    // A step at either end of the range either wraps or is blocked, depending on MODE.
    always_comb begin
        nxt      = cntr;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (clr) begin
            nxt = INIT_V;
        end else if (ld) begin
            nxt = ldval;
        end else if (adv) begin
            if (dir) begin
                if (cntr == MAX_V) begin
                    if (MODE == 1) begin
                        sat_nxt = 1'b1;
                    end else begin
                        nxt      = '0;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    nxt = cntr + 1'b1;
                end
            end else begin
                if (cntr == '0) begin
                    if (MODE == 1) begin
                        sat_nxt = 1'b1;
                    end else begin
                        nxt      = MAX_V;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    nxt = cntr - 1'b1;
                end
            end
        end
    end

    // Gray is encoded from nxt so both registers always describe the same count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cntr <= INIT_V;
            gray <= bin2gray(INIT_V);
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            cntr <= nxt;
            gray <= bin2gray(nxt);
            wrap <= wrap_nxt;
            sat  <= sat_nxt;
        end
    end

`ifdef POWLIB_GRAYCNTR_CHECK_EN
    logic [W-1:0] gray_prev;
    logic [W-1:0] gray_dec;
    logic [W-1:0] gray_diff;
    logic         chk_arm;
    logic         chk_bad;

    assign gray_dec  = gray2bin(gray);
    assign gray_diff = gray ^ gray_prev;
    assign chk_bad   = ((gray_diff & (gray_diff - 1'b1)) != '0) || (gray_dec != cntr);

    // chk_arm marks that the last transition came from a step or hold, not from reset, clr or ld.
    always_ff @(posedge clk) begin
        gray_prev <= gray;
        if (!rst) begin
            chk_arm <= 1'b0;
            err     <= 1'b0;
        end else begin
            chk_arm <= !clr && !ld;
            if (chk_arm && chk_bad) begin
                err <= 1'b1;
                $display("powlib_graycntr consistency violation at %0t: gray=%0h prev=%0h cntr=%0h",
                         $time, gray, gray_prev, cntr);
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_powlib_graycntr.sv
// Scoreboard bench for powlib_graycntr: two instances (wrap mode INIT=0, saturate mode INIT=5) share stimulus.
// Expected values come from an integer reference model; a negedge monitor pops and compares every cycle.
module tb_powlib_graycntr;

    typedef struct {
        logic [3:0] c;
        logic [3:0] g;
        logic       w;
        logic       s;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       adv = 1'b0;
    logic       dir = 1'b0;
    logic       clr = 1'b0;
    logic       ld  = 1'b0;
    logic [3:0] ldval = 4'd0;

    logic [3:0] ca, ga, cb, gb;
    logic       wa, sa, ea, wb, sb, eb;

    int errors = 0;
    int checks = 0;
    int va = 0;
    int vb = 5;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    powlib_graycntr #(.W(4), .INIT(0), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .clr(clr), .ld(ld), .ldval(ldval),
        .cntr(ca), .gray(ga), .wrap(wa), .sat(sa), .err(ea)
    );

    powlib_graycntr #(.W(4), .INIT(5), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .adv(adv), .dir(dir), .clr(clr), .ld(ld), .ldval(ldval),
        .cntr(cb), .gray(gb), .wrap(wb), .sat(sb), .err(eb)
    );

    // Reference: integer count, stepped by plain arithmetic within 0..15.
    function automatic exp_t model(inout int v, input int init, input int mode,
                                   input logic r, a, d, c, l, input logic [3:0] lv);
        exp_t x;
        x.w = 1'b0;
        x.s = 1'b0;
        x.e = 1'b0;
        if (!r || c) begin
            v = init;
        end else if (l) begin
            v = int'(lv);
        end else if (a) begin
            int t = d ? v + 1 : v - 1;
            if (t > 15 || t < 0) begin
                if (mode == 1) begin
                    x.s = 1'b1;
                end else begin
                    v   = (t + 16) % 16;
                    x.w = 1'b1;
                end
            end else begin
                v = t;
            end
        end
        x.c = 4'(v);
        x.g = 4'(v ^ (v >> 1));
        return x;
    endfunction

    task automatic drv(input logic r, a, d, c, l, input logic [3:0] lv);
        rst = r; adv = a; dir = d; clr = c; ld = l; ldval = lv;
        qa.push_back(model(va, 0, 0, r, a, d, c, l, lv));
        qb.push_back(model(vb, 5, 1, r, a, d, c, l, lv));
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input exp_t x, input logic [3:0] c, g,
                       input logic w, s, e);
        checks++;
        if (c !== x.c || g !== x.g || w !== x.w || s !== x.s || e !== x.e) begin
            errors++;
            $display("FAIL %s t=%0t got cntr=%0d gray=%0d wrap=%0b sat=%0b err=%0b want cntr=%0d gray=%0d wrap=%0b sat=%0b err=%0b",
                     nm, $time, c, g, w, s, e, x.c, x.g, x.w, x.s, x.e);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%0b want=%0b", nm, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) cmp("dut_a", qa.pop_front(), ca, ga, wa, sa, ea);
        if (qb.size() > 0) cmp("dut_b", qb.pop_front(), cb, gb, wb, sb, eb);
    end

    initial begin
        // Reset then run up through one wrap.
        repeat (2) drv(0, 0, 0, 0, 0, 4'd0);
        repeat (20) drv(1, 1, 1, 0, 0, 4'd0);
        // Count down across zero from 2.
        drv(1, 0, 0, 0, 1, 4'd2);
        repeat (4) drv(1, 1, 0, 0, 0, 4'd0);
        // Saturate at the top, then step back down.
        drv(1, 0, 0, 0, 1, 4'd14);
        repeat (4) drv(1, 1, 1, 0, 0, 4'd0);
        drv(1, 1, 0, 0, 0, 4'd0);
        // Blocked step at the bottom, then idle cycle clears sat.
        drv(1, 0, 0, 0, 1, 4'd0);
        repeat (2) drv(1, 1, 0, 0, 0, 4'd0);
        drv(1, 0, 0, 0, 0, 4'd0);
        // Priority: clr over ld over adv.
        drv(1, 1, 1, 1, 1, 4'd9);
        drv(1, 1, 1, 0, 1, 4'd9);
        // Reset mid-count with adv high, then resume.
        drv(1, 0, 0, 1, 0, 4'd0);
        repeat (7) drv(1, 1, 1, 0, 0, 4'd0);
        drv(0, 1, 1, 0, 0, 4'd0);
        repeat (3) drv(1, 1, 1, 0, 0, 4'd0);
        // Randomised run.
        for (int i = 0; i < 10000; i++) begin
            logic r, a, d, c, l;
            r = ($urandom_range(0, 63) != 0);
            a = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            c = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 15) == 0);
            drv(r, a, d, c, l, 4'($urandom));
        end
`ifdef POWLIB_GRAYCNTR_CHECK_EN
        begin
            logic [3:0] fg;
            repeat (2) drv(1, 0, 0, 0, 0, 4'd0);
            @(negedge clk);
            #1;
            chk1("err_before_force", ea, 1'b0);
            fg = ga ^ 4'b0110;
            force dut_a.gray = fg;
            @(posedge clk);
            #1;
            chk1("err_after_force", ea, 1'b1);
            release dut_a.gray;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                #1;
                chk1("err_sticky", ea, 1'b1);
            end
        end
`endif
        drv(0, 0, 0, 0, 0, 4'd0);
        repeat (3) drv(1, 1, 1, 0, 0, 4'd0);
        @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain pending_a=%0d pending_b=%0d want 0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
